// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC and assembles each 32-bit instruction from
// four granted byte reads on a shared 8-bit port, with stall hold and branch redirect.
module if_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  br,
    input  logic [ADDR_WIDTH-1:0] br_addr,
    input  logic                  mem_grant,
    input  logic [7:0]            mem_din,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  inst_valid,
    output logic [31:0]           inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    typedef enum logic [2:0] {IDLE, REQ0, REQ1, REQ2, REQ3, LAST, VALID} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
    logic                    granted_reg, granted_next;
    logic [1:0]              byte_sel;
    logic [2:0]              capture_en;
    logic [23:0]             inst_buf;
    logic                    redirect;

    assign redirect = br && (state_reg != IDLE);

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        granted_next = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        byte_sel     = 2'd0;
        capture_en   = 3'b000;
        case (state_reg)
            IDLE: state_next = REQ0;
            REQ0: begin
                mem_req      = 1'b1;
                byte_sel     = 2'd0;
                granted_next = mem_grant;
                if (mem_grant) state_next = REQ1;
            end
            REQ1: begin
                mem_req       = 1'b1;
                byte_sel      = 2'd1;
                granted_next  = mem_grant;
                capture_en[0] = granted_reg;
                if (mem_grant) state_next = REQ2;
            end
            REQ2: begin
                mem_req       = 1'b1;
                byte_sel      = 2'd2;
                granted_next  = mem_grant;
                capture_en[1] = granted_reg;
                if (mem_grant) state_next = REQ3;
            end
            REQ3: begin
                mem_req       = 1'b1;
                byte_sel      = 2'd3;
                granted_next  = mem_grant;
                capture_en[2] = granted_reg;
                if (mem_grant) state_next = LAST;
            end
            LAST: state_next = VALID;
            VALID: begin
                if (!stall_i) begin
                    pc_next    = pc_reg + ADDR_WIDTH'(4);
                    state_next = REQ0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (mem_req) begin
            mem_addr = pc_reg + {{(ADDR_WIDTH-2){1'b0}}, byte_sel};
        end
        // A redirect beats stall and grant; whatever byte arrives next is dropped.
        if (redirect) begin
            state_next   = REQ0;
            pc_next      = {br_addr[ADDR_WIDTH-1:2], 2'b00};
            granted_next = 1'b0;
            capture_en   = 3'b000;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg      <= RESET_PC;
            granted_reg <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            granted_reg <= granted_next;
        end
    end

    // Bytes 0..2 land in their lanes one cycle after their grant; byte 3 goes straight out in LAST.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : byte_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)             lane_reg <= 8'h00;
                else if (capture_en[gi]) lane_reg <= mem_din;
            end
            assign inst_buf[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inst_o     <= 32'h0;
            pc_o       <= '0;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            inst_valid <= 1'b0;
        end else if (state_reg == LAST) begin
            inst_o     <= {mem_din, inst_buf};
            pc_o       <= pc_reg;
            inst_valid <= 1'b1;
        end else if (state_reg == VALID && !stall_i) begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a vector table for straight-line fetch and stall,
// then hand sequences for grant dropout, branches, async reset and PC wrap.
module tb_if_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        mem_grant = 1'b0;
    logic [7:0]  mem_din = 8'hEE;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        inst_valid;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    logic [7:0]  mem [0:511];
    int          n_vec = 0;
    int          n_bad = 0;

    localparam logic [31:0] W0 = 32'h00100513;
    localparam logic [31:0] W1 = 32'h00000093;

    typedef struct {
        logic        st;
        logic        g;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [19];

    if_fetch_ctrl #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .stall_i(stall_i), .br(br), .br_addr(br_addr),
        .mem_grant(mem_grant), .mem_din(mem_din), .mem_req(mem_req), .mem_addr(mem_addr),
        .inst_valid(inst_valid), .inst_o(inst_o), .pc_o(pc_o)
    );

    always #5 clock = ~clock;

    // Memory responder: data follows a granted request by one cycle, junk otherwise.
    always @(posedge clock) begin
        if (mem_req && mem_grant) mem_din <= mem[mem_addr[8:0]];
        else                      mem_din <= 8'hEE;
    end

    function automatic logic [7:0] mb(input logic [31:0] a);
        return mem[a[8:0]];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction

    function automatic vec_t mk(input logic st, input logic g, input logic req,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] inst, input logic [31:0] pc);
        vec_t r;
        r.st = st; r.g = g; r.req = req; r.addr = addr; r.v = v; r.inst = inst; r.pc = pc;
        return r;
    endfunction

    task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                         input logic e_v, input logic [31:0] e_inst, input logic [31:0] e_pc);
        n_vec++;
        if (mem_req !== e_req || mem_addr !== e_addr || inst_valid !== e_v ||
            inst_o !== e_inst || pc_o !== e_pc) begin
            n_bad++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b inst=%h pc=%h, want req=%0b addr=%h valid=%0b inst=%h pc=%h",
                     name, mem_req, mem_addr, inst_valid, inst_o, pc_o,
                     e_req, e_addr, e_v, e_inst, e_pc);
        end else begin
            $display("ok   %s: req=%0b addr=%h valid=%0b inst=%h pc=%h",
                     name, mem_req, mem_addr, inst_valid, inst_o, pc_o);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge and check the state-decoded outputs.
    task automatic step(input string name, input logic st, input logic b, input logic [31:0] ba,
                        input logic g, input logic e_req, input logic [31:0] e_addr,
                        input logic e_v, input logic [31:0] e_inst, input logic [31:0] e_pc);
        @(negedge clock);
        stall_i = st; br = b; br_addr = ba; mem_grant = g;
        #1;
        check(name, e_req, e_addr, e_v, e_inst, e_pc);
    endtask

    // Assert reset between edges, confirm outputs clear at once, release just after a rising edge.
    task automatic do_reset(input string name);
        reset = 1'b0;
        stall_i = 1'b0; br = 1'b0; br_addr = 32'h0; mem_grant = 1'b1;
        #1;
        check(name, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h00;

        tbl[0]  = mk(0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        tbl[1]  = mk(0, 1, 1, 32'h0, 0, 32'h0, 32'h0);
        tbl[2]  = mk(0, 1, 1, 32'h1, 0, 32'h0, 32'h0);
        tbl[3]  = mk(0, 1, 1, 32'h2, 0, 32'h0, 32'h0);
        tbl[4]  = mk(0, 1, 1, 32'h3, 0, 32'h0, 32'h0);
        tbl[5]  = mk(0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        tbl[6]  = mk(0, 1, 0, 32'h0, 1, W0, 32'h0);
        tbl[7]  = mk(0, 1, 1, 32'h4, 0, W0, 32'h0);
        tbl[8]  = mk(0, 1, 1, 32'h5, 0, W0, 32'h0);
        tbl[9]  = mk(0, 1, 1, 32'h6, 0, W0, 32'h0);
        tbl[10] = mk(0, 1, 1, 32'h7, 0, W0, 32'h0);
        tbl[11] = mk(0, 1, 0, 32'h0, 0, W0, 32'h0);
        for (int i = 12; i < 17; i++) tbl[i] = mk(1, 1, 0, 32'h0, 1, W1, 32'h4);
        tbl[17] = mk(0, 1, 0, 32'h0, 1, W1, 32'h4);
        tbl[18] = mk(0, 1, 1, 32'h8, 0, W1, 32'h4);

        // Straight-line fetch followed by a five-cycle stall.
        do_reset("reset_state");
        for (int i = 0; i < 19; i++)
            step($sformatf("line_%0d", i), tbl[i].st, 1'b0, 32'h0, tbl[i].g,
                 tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].inst, tbl[i].pc);

        // Grant dropout for three cycles in REQ2.
        do_reset("reset_dropout");
        step("drop_idle", 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        step("drop_req0", 0, 0, 0, 1, 1, 32'h0, 0, 32'h0, 32'h0);
        step("drop_req1", 0, 0, 0, 1, 1, 32'h1, 0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++)
            step($sformatf("drop_wait%0d", k), 0, 0, 0, 0, 1, 32'h2, 0, 32'h0, 32'h0);
        step("drop_regrant", 0, 0, 0, 1, 1, 32'h2, 0, 32'h0, 32'h0);
        step("drop_req3", 0, 0, 0, 1, 1, 32'h3, 0, 32'h0, 32'h0);
        step("drop_last", 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        step("drop_valid", 0, 0, 0, 1, 0, 32'h0, 1, W0, 32'h0);

        // Branch in REQ2 with a granted (stale) byte in flight.
        do_reset("reset_branch");
        step("br_idle", 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        step("br_req0", 0, 0, 0, 1, 1, 32'h0, 0, 32'h0, 32'h0);
        step("br_req1", 0, 0, 0, 1, 1, 32'h1, 0, 32'h0, 32'h0);
        step("br_req2", 0, 1, 32'h103, 1, 1, 32'h2, 0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++)
            step($sformatf("br_fetch%0d", k), 0, 0, 0, 1, 1, 32'h100 + k, 0, 32'h0, 32'h0);
        step("br_last", 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);

        // Branch while stalled in VALID.
        step("stbr_valid", 1, 0, 0, 1, 0, 32'h0, 1, word_at(32'h100), 32'h100);
        step("stbr_pulse", 1, 1, 32'h40, 1, 0, 32'h0, 1, word_at(32'h100), 32'h100);
        for (int k = 0; k < 4; k++)
            step($sformatf("stbr_fetch%0d", k), 0, 0, 0, 1, 1, 32'h40 + k, 0,
                 word_at(32'h100), 32'h100);
        step("stbr_last", 0, 0, 0, 1, 0, 32'h0, 0, word_at(32'h100), 32'h100);
        step("stbr_valid2", 0, 0, 0, 1, 0, 32'h0, 1, word_at(32'h40), 32'h40);
        for (int k = 0; k < 4; k++)
            step($sformatf("next_fetch%0d", k), 0, 0, 0, 1, 1, 32'h44 + k, 0,
                 word_at(32'h40), 32'h40);

        // Async reset in REQ3, between edges.
        #2;
        do_reset("async_reset");
        step("rst_idle", 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);

        // Branch in REQ0 to a near-top address: low bits ignored, PC wraps to 0.
        step("wrap_br", 0, 1, 32'hFFFF_FFFE, 1, 1, 32'h0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++)
            step($sformatf("wrap_fetch%0d", k), 0, 0, 0, 1, 1, 32'hFFFF_FFFC + k, 0,
                 32'h0, 32'h0);
        step("wrap_last", 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        step("wrap_valid", 0, 0, 0, 1, 0, 32'h0, 1, word_at(32'hFFFF_FFFC), 32'hFFFF_FFFC);
        step("wrap_next", 0, 0, 0, 1, 1, 32'h0, 0, word_at(32'hFFFF_FFFC), 32'hFFFF_FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
